id_skid_stage: RTL and testbench

ID_SKID_STAGE -- requirements
Module: id_skid_stage

---
 rtl/id_skid_stage_pkg.sv | 49 ++++
 rtl/id_skid_stage_if.sv | 30 +++
 rtl/id_skid_stage_id_field_decode.sv | 39 +++
 rtl/id_skid_stage.sv | 110 +++++++++++
 tb/tb_id_skid_stage.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/id_skid_stage_pkg.sv
// Shared types and constants for the decode skid stage: instruction types,
// extender select encodings, field positions and the buffer state enum.
package id_skid_stage_pkg;

    typedef enum logic [2:0] {
        TYPE_A   = 3'b000,
        TYPE_B   = 3'b001,
        TYPE_C   = 3'b010,
        TYPE_D_L = 3'b011,
        TYPE_D_U = 3'b100,
        TYPE_F   = 3'b101,
        TYPE_G   = 3'b110,
        TYPE_ILL = 3'b111
    } instr_type_e;

    localparam int TYPE_HI = 31;
    localparam int TYPE_LO = 29;
    localparam int U_BIT   = 28;
    localparam int IMM_HI  = 25;
    localparam int IMM_LO  = 0;

    localparam logic [1:0] IMM_SEL_BF   = 2'b00;
    localparam logic [1:0] IMM_SEL_C    = 2'b01;
    localparam logic [1:0] IMM_SEL_G    = 2'b10;
    localparam logic [3:0] IMM_SRC_D_LO = 4'b1100;
    localparam logic [3:0] IMM_SRC_D_HI = 4'b1110;
    localparam logic [3:0] IMM_SRC_NONE = 4'b0000;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [25:0] imm_in;
        logic [3:0]  imm_src;
        logic        uses_imm;
        logic        illegal;
    } entry_t;

    // Sign-selectable extender modes carry the unsigned flag in bit 0.
    function automatic logic [3:0] imm_src_sel(input logic [1:0] sel, input logic u);
        return {sel, 1'b0, u};
    endfunction

endpackage

// File: rtl/id_skid_stage_if.sv
// Fetch-side and execute-side signals of the decode skid stage.
// Handshake: a word moves when valid & ready are both high on a rising edge;
// the sender holds payload stable while valid=1 and ready=0.
interface id_skid_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [25:0] out_imm_in;
    logic [3:0]  out_imm_src;
    logic        out_uses_imm;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_imm_in,
               out_imm_src, out_uses_imm, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_imm_in,
               out_imm_src, out_uses_imm, out_illegal
    );
endinterface

// File: rtl/id_skid_stage_id_field_decode.sv
// Combinational instruction field decode: immediate field, extender select,
// immediate usage and illegal-type detection.
module id_field_decode
    import id_skid_stage_pkg::*;
(
    input  logic [31:0] instr,
    output logic [25:0] imm_in,
    output logic [3:0]  imm_src,
    output logic        uses_imm,
    output logic        illegal
);

    instr_type_e itype;
    logic        u;

    assign itype  = instr_type_e'(instr[TYPE_HI:TYPE_LO]);
    assign u      = instr[U_BIT];
    assign imm_in = instr[IMM_HI:IMM_LO];

    always_comb begin
        imm_src  = IMM_SRC_NONE;
        uses_imm = 1'b1;
        illegal  = 1'b0;
        case (itype)
            TYPE_A:   uses_imm = 1'b0;
            TYPE_B,
            TYPE_F:   imm_src  = imm_src_sel(IMM_SEL_BF, u);
            TYPE_C:   imm_src  = imm_src_sel(IMM_SEL_C, u);
            TYPE_G:   imm_src  = imm_src_sel(IMM_SEL_G, u);
            TYPE_D_L: imm_src  = IMM_SRC_D_LO;
            TYPE_D_U: imm_src  = IMM_SRC_D_HI;
            default: begin
                uses_imm = 1'b0;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_skid_stage.sv
// Two-entry decode skid buffer between fetch and execute; all outputs registered.
// Define ID_ILLEGAL_TRAP_EN to forward illegal words flagged instead of dropping them.
module id_skid_stage
    import id_skid_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    id_skid_stage_if.slave   bus,
    output state_e           state_dbg
);

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;

    logic [25:0] dec_imm_in;
    logic [3:0]  dec_imm_src;
    logic        dec_uses_imm;
    logic        dec_illegal;
    logic        enq_ok;
    logic        in_fire;
    logic        out_fire;
    logic        push;

    id_field_decode u_decode (
        .instr    (bus.in_instr),
        .imm_in   (dec_imm_in),
        .imm_src  (dec_imm_src),
        .uses_imm (dec_uses_imm),
        .illegal  (dec_illegal)
    );

    always_comb begin
        in_entry.pc       = bus.in_pc;
        in_entry.instr    = bus.in_instr;
        in_entry.imm_in   = dec_imm_in;
        in_entry.imm_src  = dec_imm_src;
        in_entry.uses_imm = dec_uses_imm;
`ifdef ID_ILLEGAL_TRAP_EN
        in_entry.illegal  = dec_illegal;
        enq_ok            = 1'b1;
`else
        // Illegal words are consumed from fetch but never enter the buffer.
        in_entry.illegal  = 1'b0;
        enq_ok            = ~dec_illegal;
`endif
    end

    assign bus.in_ready  = (state_q != S_TWO);
    assign bus.out_valid = (state_q != S_EMPTY);
    assign in_fire       = bus.in_valid & bus.in_ready;
    assign out_fire      = bus.out_valid & bus.out_ready;
    assign push          = in_fire & enq_ok;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (push) begin
                    state_d = S_ONE;
                    head_d  = in_entry;
                end
            end
            S_ONE: begin
                if (push && out_fire) begin
                    head_d = in_entry;
                end else if (push) begin
                    state_d = S_TWO;
                    skid_d  = in_entry;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (out_fire) begin
                    state_d = S_ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (bus.flush) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.out_pc       = head_q.pc;
    assign bus.out_instr    = head_q.instr;
    assign bus.out_imm_in   = head_q.imm_in;
    assign bus.out_imm_src  = head_q.imm_src;
    assign bus.out_uses_imm = head_q.uses_imm;
    assign bus.out_illegal  = head_q.illegal;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_id_skid_stage.sv
// Directed self-checking bench for id_skid_stage; expected head-of-line words
// are tracked in a queue and field values are hand-computed constants.
module tb_id_skid_stage;
    import id_skid_stage_pkg::*;

    logic   clk;
    logic   rst;
    state_e state_dbg;
    int     total;
    int     bad;
    logic [31:0] exp_q[$];

    id_skid_stage_if bus ();

    id_skid_stage dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_in(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = v;
        bus.in_instr = instr;
        bus.in_pc    = pc;
    endtask

    // Compare the head of the stage against the oldest expected word.
    task automatic check_head(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
        end else begin
            check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
            check({tag, "_instr"}, bus.out_instr, exp_q[0]);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive_in(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_imm_src", {28'd0, bus.out_imm_src}, 32'd0);
        check("rst_illegal", {31'd0, bus.out_illegal}, 32'd0);
        check("rst_out_pc", bus.out_pc, 32'd0);

        // Single word, one-cycle latency
        bus.out_ready = 1'b1;
        drive_in(1'b1, 32'h2000_1234, 32'h40);
        tick();
        drive_in(1'b0, 32'h0, 32'h0);
        check("b_valid", {31'd0, bus.out_valid}, 32'd1);
        check("b_imm_src", {28'd0, bus.out_imm_src}, 32'h0);
        check("b_imm_in", {6'd0, bus.out_imm_in}, 32'h0001234);
        check("b_pc", bus.out_pc, 32'h40);
        check("b_uses_imm", {31'd0, bus.out_uses_imm}, 32'd1);
        tick();
        check("b_drained", {31'd0, bus.out_valid}, 32'd0);

        // Fill to TWO under back-pressure, then drain in order
        bus.out_ready = 1'b0;
        drive_in(1'b1, 32'h4000_0001, 32'h44);
        exp_q.push_back(32'h4000_0001);
        tick();
        drive_in(1'b1, 32'h6000_0002, 32'h48);
        exp_q.push_back(32'h6000_0002);
        tick();
        check("two_state", {30'd0, state_dbg}, {30'd0, S_TWO});
        check("two_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("two_imm_src_c", {28'd0, bus.out_imm_src}, 32'h4);
        check_head("two_head");
        drive_in(1'b1, 32'h2000_0099, 32'h4c);
        tick();
        drive_in(1'b0, 32'h0, 32'h0);
        check_head("two_stall");
        check("two_stall_pc", bus.out_pc, 32'h44);
        bus.out_ready = 1'b1;
        tick();
        void'(exp_q.pop_front());
        check_head("drain1");
        check("drain1_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("drain1_imm_src", {28'd0, bus.out_imm_src}, 32'hC);
        tick();
        void'(exp_q.pop_front());
        check_head("drain2");

        // Back-to-back streaming with d upper / d lower / g unsigned
        drive_in(1'b1, 32'h8000_0ABC, 32'h50);
        tick();
        check("du_imm_src", {28'd0, bus.out_imm_src}, 32'hE);
        check("du_imm_in", {6'd0, bus.out_imm_in}, 32'h0000ABC);
        drive_in(1'b1, 32'h6000_0ABC, 32'h54);
        tick();
        check("dl_imm_src", {28'd0, bus.out_imm_src}, 32'hC);
        check("dl_pc", bus.out_pc, 32'h54);
        drive_in(1'b1, 32'hD000_0000, 32'h58);
        tick();
        check("g_imm_src", {28'd0, bus.out_imm_src}, 32'h9);
        drive_in(1'b1, 32'h0000_0005, 32'h5c);
        tick();
        check("a_uses_imm", {31'd0, bus.out_uses_imm}, 32'd0);
        check("a_imm_src", {28'd0, bus.out_imm_src}, 32'h0);
        drive_in(1'b0, 32'h0, 32'h0);
        tick();
        check("stream_drained", {31'd0, bus.out_valid}, 32'd0);

        // Flush while TWO with a word presented
        bus.out_ready = 1'b0;
        drive_in(1'b1, 32'h2000_0011, 32'h60);
        tick();
        drive_in(1'b1, 32'h2000_0022, 32'h64);
        tick();
        drive_in(1'b1, 32'h2000_0033, 32'h68);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        drive_in(1'b0, 32'h0, 32'h0);
        check("flush2_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush2_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_head("flush2_quiet");
        end

        // Flush while ONE: the word accepted that cycle is dropped
        bus.out_ready = 1'b0;
        drive_in(1'b1, 32'h2000_0044, 32'h70);
        tick();
        drive_in(1'b1, 32'h2000_0055, 32'h74);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        drive_in(1'b0, 32'h0, 32'h0);
        check("flush1_valid", {31'd0, bus.out_valid}, 32'd0);
        drive_in(1'b1, 32'h2000_0066, 32'h78);
        exp_q.push_back(32'h2000_0066);
        tick();
        drive_in(1'b0, 32'h0, 32'h0);
        check_head("post_flush");
        bus.out_ready = 1'b1;
        tick();
        void'(exp_q.pop_front());
        check_head("post_flush_drain");

        // Illegal type 111
        bus.out_ready = 1'b0;
        drive_in(1'b1, 32'hE000_0000, 32'h80);
        tick();
        drive_in(1'b0, 32'h0, 32'h0);
`ifdef ID_ILLEGAL_TRAP_EN
        check("ill_valid", {31'd0, bus.out_valid}, 32'd1);
        check("ill_flag", {31'd0, bus.out_illegal}, 32'd1);
        check("ill_uses_imm", {31'd0, bus.out_uses_imm}, 32'd0);
        check("ill_imm_src", {28'd0, bus.out_imm_src}, 32'h0);
`else
        check("ill_valid", {31'd0, bus.out_valid}, 32'd0);
        check("ill_in_ready", {31'd0, bus.in_ready}, 32'd1);
`endif
        bus.out_ready = 1'b1;
        tick();
        check("ill_drained", {31'd0, bus.out_valid}, 32'd0);

        // Asynchronous reset while TWO
        bus.out_ready = 1'b0;
        drive_in(1'b1, 32'h2000_0077, 32'h90);
        tick();
        drive_in(1'b1, 32'h2000_0088, 32'h94);
        tick();
        drive_in(1'b0, 32'h0, 32'h0);
        check("pre_rst_state", {30'd0, state_dbg}, {30'd0, S_TWO});
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("post_rst_pc", bus.out_pc, 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("post_rst_quiet", {31'd0, bus.out_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
